mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage unit on the consuming side of the EX/MEM pipeline register. Takes the registered EX/MEM fields, resolves branches and jumps, runs word-wide load/store transactions on the data-memory bus under a valid/ready handshake, and stalls the front of the pipeline until each access completes. Presents the write-back fields to the MEM/WB register.

## Interface
- No parameters; data width fixed at 32 bits, word accesses only.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` resets at the clock edge).
- `PC_number_in` in 32: PC of the instruction in MEM.
- `RegWrite_in` in 1: register write enable from EX/MEM.
- `MemWrite_in` in 1: store enable from EX/MEM.
- `MemRead_in` in 1: load enable from EX/MEM.
- `MemtoReg_in` in 1: write-back selects load data.
- `Branch_in` in 2: 00 none, 01 beq, 10 bne, 11 unconditional.
- `is_jal_in` in 1: link instruction; write-back is PC+4.
- `Rd_in` in 5: destination register.
- `zero_in` in 1: ALU zero flag.
- `ALU_result_in` in 32: ALU result, also the memory address.
- `PC_add_imm_in` in 32: branch/jump target.
- `Read_data_2_in` in 32: store data.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: word address `{addr[31:2],2'b00}`.
- `dmem_wdata` out 32: store data.
- `dmem_ready` in 1: completes the transaction in the cycle it is high with `dmem_req`.
- `dmem_rdata` in 32: load data, valid when `dmem_ready=1`.
- `mem_stall` out 1: hold IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- `PCSrc` out 1: take branch/jump.
- `PC_target` out 32: equals `PC_add_imm_in`.
- `RegWrite_out` out 1, `MemtoReg_out` out 1, `Rd_out` out 5: to MEM/WB.
- `wb_data_out` out 32: `is_jal` → PC+4; else `MemtoReg` → load data; else ALU result.
- `misalign_err` out 1: one-cycle pulse for a misaligned access.

## Operation
- States:
  - IDLE: no access in flight.
  - REQ: bus transaction open.
  - DONE: transaction finished; pipeline released.
- IDLE, `MemRead_in|MemWrite_in` and `ALU_result_in[1:0]==0`:
  - Latch address, write data and `we`.
  - Next state REQ.
  - `mem_stall=1` combinationally this cycle.
  - If both `MemRead_in` and `MemWrite_in` are set, the store wins.
- IDLE, memory op with `ALU_result_in[1:0]!=0`:
  - No bus transaction and no stall.
  - `misalign_err` pulses for one cycle (registered, visible next cycle).
  - `RegWrite_out` is forced to 0 for that instruction.
- REQ:
  - `dmem_req=1` with the latched `we`/`addr`/`wdata`, held stable until `dmem_ready`.
  - `mem_stall=1`.
  - On `dmem_ready=1`: a load captures `dmem_rdata` into `load_data`; next state DONE.
  - No timeout; the unit waits indefinitely.
- DONE:
  - `dmem_req=0`, `mem_stall=0`; the pipeline advances at the end of this cycle.
  - Next state IDLE.
- Branches:
  - `PCSrc = (Branch==01 & zero) | (Branch==10 & !zero) | (Branch==11) | is_jal`.
  - `PCSrc` is gated to 0 while `mem_stall=1`.
- PC+4 is a 32-bit add that wraps modulo 2^32.
- Write-back:
  - `RegWrite_out = RegWrite_in & !mem_stall & !misalign`.
  - `Rd_out` and `MemtoReg_out` pass through.
- Reset (any state, including mid-REQ):
  - Next edge: state IDLE.
  - `dmem_req`, `misalign_err` and `load_data` are 0.
  - A pending transaction is abandoned.

## Timing
- Reset values: `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`, `misalign_err=0`, `load_data=0`, state IDLE.
- Combinational outputs during reset follow their input equations.
- `dmem_*` outputs are registered.
- `mem_stall`, `PCSrc`, `PC_target`, `wb_data_out` and `RegWrite_out` are combinational from the inputs and state.
- Access with zero wait states takes 3 cycles:
  - c0: IDLE detect, stall.
  - c1: REQ with `ready`, stall.
  - c2: DONE, no stall.
- Each `dmem_ready=0` cycle in REQ adds one cycle.
- `dmem_ready` outside REQ is ignored.
- Non-memory instructions take 1 cycle and never stall.
- Back-to-back accesses have one DONE/IDLE boundary between them. `dmem_req` is low for at least 2 cycles (DONE, IDLE) between transactions.

## Test plan
- Load `ALU_result=0x100`, `ready` high in the first REQ cycle, `rdata=0xDEADBEEF`:
  - `dmem_req` high exactly 1 cycle at addr 0x100.
  - `mem_stall` 1,1,0.
  - `wb_data_out=0xDEADBEEF` in DONE.
- Store `addr=0x204`, `data=0x12345678`, `ready` delayed 3 cycles:
  - `dmem_req`/`we`/`addr`/`wdata` stable for 4 REQ cycles.
  - `mem_stall` high 5 cycles.
  - `RegWrite_out=0`.
- beq with `zero=1`, `PC_add_imm=0x40`: `PCSrc=1`, `PC_target=0x40`, no stall.
- Same beq with `zero=0`: `PCSrc=0`.
- jal at `PC=0xFFFFFFFC`: `PCSrc=1`, `wb_data_out=0x00000000` (wrap).
- Load at `addr=0x103`: no `dmem_req`, `misalign_err` pulses once, `RegWrite_out=0`, no stall.
- `rst=0` on the second REQ cycle of a load with `ready` low:
  - Next cycle `dmem_req=0`, state IDLE, `load_data=0`.
  - A late `ready` is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage unit: branch resolution, word load/store bus handshake,
// pipeline stall generation and write-back field selection.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_number_in,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemtoReg_in,
    input  logic [1:0]  Branch_in,
    input  logic        is_jal_in,
    input  logic [4:0]  Rd_in,
    input  logic        zero_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] PC_add_imm_in,
    input  logic [31:0] Read_data_2_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        PCSrc,
    output logic [31:0] PC_target,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] wb_data_out,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        mem_op;
    logic        aligned;
    logic        start;
    logic        misalign;
    logic        fire;
    logic        take;
    logic [31:0] load_data;
    logic [31:0] pc_plus4;

    assign mem_op   = MemRead_in | MemWrite_in;
    assign aligned  = (ALU_result_in[1:0] == 2'b00);
    assign pc_plus4 = PC_number_in + 32'd4;

    // State register; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, stall and transaction start/complete strobes.
    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        start     = 1'b0;
        misalign  = 1'b0;
        fire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        start     = 1'b1;
                        mem_stall = 1'b1;
                        state_nx  = REQ;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ready) begin
                    fire     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus outputs held stable from start until the ready handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            misalign_err <= 1'b0;
            load_data    <= 32'd0;
        end else begin
            misalign_err <= misalign;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_in;
                dmem_addr  <= {ALU_result_in[31:2], 2'b00};
                dmem_wdata <= Read_data_2_in;
            end
            if (fire) begin
                dmem_req <= 1'b0;
                if (!dmem_we) begin
                    load_data <= dmem_rdata;
                end
            end
        end
    end

    // Branch decision, suppressed while the stage is stalled.
    always_comb begin
        take = is_jal_in;
        unique case (Branch_in)
            2'b01:   take = take | zero_in;
            2'b10:   take = take | ~zero_in;
            2'b11:   take = 1'b1;
            default: take = take;
        endcase
        PCSrc = take & ~mem_stall;
    end

    // Write-back field selection toward MEM/WB.
    always_comb begin
        if (is_jal_in) begin
            wb_data_out = pc_plus4;
        end else if (MemtoReg_in) begin
            wb_data_out = load_data;
        end else begin
            wb_data_out = ALU_result_in;
        end
        RegWrite_out = RegWrite_in & ~mem_stall & ~misalign;
    end

    assign PC_target    = PC_add_imm_in;
    assign MemtoReg_out = MemtoReg_in;
    assign Rd_out       = Rd_in;

endmodule
